// File: rtl/led_chaser_prescaled.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_chaser_prescaled                                                       |
// | WIDTH-bit LED pattern chaser stepped by a tap-selectable prescaler.        |
// | Optional hold input enabled by defining LED_CHASER_HOLD_EN.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module led_chaser_prescaled #(
    parameter int WIDTH    = 6,
    parameter int DIV_BITS = 16,
    parameter int TAP0     = 3,
    parameter int TAP1     = 6,
    parameter int TAP2     = 8,
    parameter int TAP3     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             bypass,
    input  logic [1:0]       div_sel,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef LED_CHASER_HOLD_EN
    input  logic             hold,
`endif
    output logic [WIDTH-1:0] leds,
    output logic             tick,
    output logic             wrap
);

    localparam logic [1:0] MODE_ROT_L  = 2'b00;
    localparam logic [1:0] MODE_ROT_R  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_FILL   = 2'b11;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_t;

    logic [DIV_BITS-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0]    leds_nxt, pattern_nxt;
    dir_t                dir, dir_nxt, pattern_dir;
    logic                tick_nxt, wrap_nxt;
    logic                tap_hit, step, hold_act, one_hot;

`ifdef LED_CHASER_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = 1'b0;
`endif

    // Step fires when the low T+1 prescaler bits are all ones for the selected tap.
    always_comb begin
        tap_hit = 1'b0;
        case (div_sel)
            2'd0:    tap_hit = &cnt[TAP0:0];
            2'd1:    tap_hit = &cnt[TAP1:0];
            2'd2:    tap_hit = &cnt[TAP2:0];
            default: tap_hit = &cnt[TAP3:0];
        endcase
    end

    assign step    = enable & ~hold_act & (bypass | tap_hit);
    assign one_hot = (leds != '0) && ((leds & (leds - ONE)) == '0);

    always_comb begin
        pattern_nxt = leds;
        pattern_dir = dir;
        case (mode)
            MODE_ROT_L: begin
                if (leds == '0)            pattern_nxt = ONE;
                else if (leds == ALL_ONES) pattern_nxt = '0;
                else                       pattern_nxt = {leds[WIDTH-2:0], leds[WIDTH-1]};
            end
            MODE_ROT_R: begin
                if (leds == '0)            pattern_nxt = ONE;
                else if (leds == ALL_ONES) pattern_nxt = '0;
                else                       pattern_nxt = {leds[0], leds[WIDTH-1:1]};
            end
            MODE_BOUNCE: begin
                // Reversal happens on the step that leaves an end bit, giving 2*(WIDTH-1) steps.
                if (!one_hot) begin
                    pattern_nxt = ONE;
                    pattern_dir = LEFT;
                end else if (dir == LEFT && leds[WIDTH-1]) begin
                    pattern_nxt = leds >> 1;
                    pattern_dir = RIGHT;
                end else if (dir == RIGHT && leds[0]) begin
                    pattern_nxt = leds << 1;
                    pattern_dir = LEFT;
                end else if (dir == LEFT) begin
                    pattern_nxt = leds << 1;
                end else begin
                    pattern_nxt = leds >> 1;
                end
            end
            MODE_FILL: begin
                if (leds == ALL_ONES) pattern_nxt = '0;
                else                  pattern_nxt = {leds[WIDTH-2:0], 1'b1};
            end
            default: pattern_nxt = leds;
        endcase
    end

    always_comb begin
        cnt_nxt  = cnt;
        leds_nxt = leds;
        dir_nxt  = dir;
        tick_nxt = 1'b0;
        wrap_nxt = 1'b0;
        if (load) begin
            cnt_nxt  = '0;
            leds_nxt = load_val;
            dir_nxt  = LEFT;
        end else begin
            if (enable) cnt_nxt = cnt + DIV_BITS'(1);
            if (step) begin
                leds_nxt = pattern_nxt;
                dir_nxt  = pattern_dir;
                tick_nxt = 1'b1;
                wrap_nxt = (pattern_nxt == ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            leds <= '0;
            dir  <= LEFT;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            leds <= leds_nxt;
            dir  <= dir_nxt;
            tick <= tick_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_chaser_prescaled.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_led_chaser_prescaled                                                    |
// | Directed vector table plus prescaler, freeze and async-reset sequences.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_led_chaser_prescaled;

    localparam int WIDTH = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             bypass = 1'b0;
    logic [1:0]       div_sel = 2'd0;
    logic [1:0]       mode = 2'd0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
`ifdef LED_CHASER_HOLD_EN
    logic             hold = 1'b0;
`endif
    logic [WIDTH-1:0] leds;
    logic             tick;
    logic             wrap;

    int checks = 0;
    int errors = 0;

    led_chaser_prescaled #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .bypass   (bypass),
        .div_sel  (div_sel),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
`ifdef LED_CHASER_HOLD_EN
        .hold     (hold),
`endif
        .leds     (leds),
        .tick     (tick),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             en;
        logic             byp;
        logic [1:0]       md;
        logic             ld;
        logic [WIDTH-1:0] ldv;
        logic [WIDTH-1:0] e_leds;
        logic             e_tick;
        logic             e_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic byp, input logic [1:0] md,
                       input logic ld, input logic [WIDTH-1:0] ldv,
                       input logic [WIDTH-1:0] el, input logic et, input logic ew);
        vec_t v;
        v.en = en; v.byp = byp; v.md = md; v.ld = ld; v.ldv = ldv;
        v.e_leds = el; v.e_tick = et; v.e_wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int first_tick, second_tick, freeze_bad, freeze_ticks, resume_edge;
    logic [WIDTH-1:0] frozen;

    initial begin
        // ROT_L bypass run, wraps on 1st and 7th step
        add(1,1,2'd0,0,6'b000000, 6'b000001,1,1);
        add(1,1,2'd0,0,6'b000000, 6'b000010,1,0);
        add(1,1,2'd0,0,6'b000000, 6'b000100,1,0);
        add(1,1,2'd0,0,6'b000000, 6'b001000,1,0);
        add(1,1,2'd0,0,6'b000000, 6'b010000,1,0);
        add(1,1,2'd0,0,6'b000000, 6'b100000,1,0);
        add(1,1,2'd0,0,6'b000000, 6'b000001,1,1);
        // load coincident with a step wins, then all-ones goes to zero
        add(1,1,2'd0,1,6'b101101, 6'b101101,0,0);
        add(1,1,2'd0,0,6'b000000, 6'b011011,1,0);
        add(1,1,2'd0,1,6'b111111, 6'b111111,0,0);
        add(1,1,2'd0,0,6'b000000, 6'b000000,1,0);
        add(1,1,2'd0,0,6'b000000, 6'b000001,1,1);
        // ROT_R
        add(1,1,2'd1,0,6'b000000, 6'b100000,1,0);
        add(1,1,2'd1,0,6'b000000, 6'b010000,1,0);
        // enable=0 freezes; load still acts
        add(0,1,2'd1,0,6'b000000, 6'b010000,0,0);
        add(0,1,2'd1,1,6'b010101, 6'b010101,0,0);
        add(0,1,2'd1,0,6'b000000, 6'b010101,0,0);
        // FILL from zero
        add(1,1,2'd3,1,6'b000000, 6'b000000,0,0);
        add(1,1,2'd3,0,6'b000000, 6'b000001,1,1);
        add(1,1,2'd3,0,6'b000000, 6'b000011,1,0);
        add(1,1,2'd3,0,6'b000000, 6'b000111,1,0);
        add(1,1,2'd3,0,6'b000000, 6'b001111,1,0);
        add(1,1,2'd3,0,6'b000000, 6'b011111,1,0);
        add(1,1,2'd3,0,6'b000000, 6'b111111,1,0);
        add(1,1,2'd3,0,6'b000000, 6'b000000,1,0);
        add(1,1,2'd3,0,6'b000000, 6'b000001,1,1);
        // BOUNCE from zero, period 10
        add(1,1,2'd2,1,6'b000000, 6'b000000,0,0);
        add(1,1,2'd2,0,6'b000000, 6'b000001,1,1);
        add(1,1,2'd2,0,6'b000000, 6'b000010,1,0);
        add(1,1,2'd2,0,6'b000000, 6'b000100,1,0);
        add(1,1,2'd2,0,6'b000000, 6'b001000,1,0);
        add(1,1,2'd2,0,6'b000000, 6'b010000,1,0);
        add(1,1,2'd2,0,6'b000000, 6'b100000,1,0);
        add(1,1,2'd2,0,6'b000000, 6'b010000,1,0);
        add(1,1,2'd2,0,6'b000000, 6'b001000,1,0);
        add(1,1,2'd2,0,6'b000000, 6'b000100,1,0);
        add(1,1,2'd2,0,6'b000000, 6'b000010,1,0);
        add(1,1,2'd2,0,6'b000000, 6'b000001,1,1);
        add(1,1,2'd2,0,6'b000000, 6'b000010,1,0);

        do_reset();
        #1;
        check("reset_leds", 32'(leds), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_wrap", 32'(wrap), 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            enable = vecs[i].en; bypass = vecs[i].byp; mode = vecs[i].md;
            load = vecs[i].ld; load_val = vecs[i].ldv;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].e_leds));
            check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].e_tick));
            check($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].e_wrap));
        end

        // Prescaler div_sel=0: ticks at edges 16 and 32 after release
        @(negedge clk);
        enable = 1'b0; bypass = 1'b0; load = 1'b0; mode = 2'd0; div_sel = 2'd0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b1;
        first_tick = 0; second_tick = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (tick) begin
                if (first_tick == 0) first_tick = k;
                else if (second_tick == 0) second_tick = k;
            end
        end
        check("div0_first_tick_edge", 32'(first_tick), 32'd16);
        check("div0_second_tick_edge", 32'(second_tick), 32'd32);
        check("div0_leds", 32'(leds), 32'b000010);

        // Freeze 100 cycles, then resume at the same phase (cnt=40 -> 8 more edges)
        @(negedge clk);
        enable = 1'b0;
        frozen = leds; freeze_bad = 0; freeze_ticks = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (leds !== frozen) freeze_bad++;
            if (tick !== 1'b0) freeze_ticks++;
        end
        check("freeze_leds_changes", 32'(freeze_bad), 32'd0);
        check("freeze_ticks", 32'(freeze_ticks), 32'd0);
        @(negedge clk);
        enable = 1'b1;
        resume_edge = 0;
        for (int k = 1; k <= 20 && resume_edge == 0; k++) begin
            @(posedge clk);
            #1;
            if (tick) resume_edge = k;
        end
        check("resume_tick_edge", 32'(resume_edge), 32'd8);
        check("resume_leds", 32'(leds), 32'b000100);

        // Async reset mid-cycle clears immediately
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_leds", 32'(leds), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // div_sel=3: ticks at edges 8192 and 16384
        @(negedge clk);
        enable = 1'b0; div_sel = 2'd3;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b1;
        first_tick = 0; second_tick = 0;
        for (int k = 1; k <= 17000 && second_tick == 0; k++) begin
            @(posedge clk);
            #1;
            if (tick) begin
                if (first_tick == 0) first_tick = k;
                else second_tick = k;
            end
        end
        check("div3_first_tick_edge", 32'(first_tick), 32'd8192);
        check("div3_spacing", 32'(second_tick - first_tick), 32'd8192);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
